// File: rtl/kpyd_pkg.sv
// Shared types and constants for the 4x4 keypad scan/decode path.
// Also carries the position-to-legend mapping used by the display logic.
package kpyd_pkg;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } key_event_t;

  localparam logic [3:0] col_reset_c = 4'b1110;
  localparam int         num_keys_c  = 16;

  // Nibble i holds the printed legend of key position i (row*4 + col); '*' -> E, '#' -> F.
  localparam logic [63:0] key_legend_c = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_legend(input logic [3:0] idx);
    return key_legend_c[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/kpyd_event_fifo.sv
// Synchronous FIFO of key events with valid/ready on both sides.
// A full FIFO still accepts a write in the same cycle as a read.
module kpyd_event_fifo
  import kpyd_pkg::*;
#(
  parameter int depth_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  key_event_t in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output key_event_t out_data_o
);

  localparam int               ptr_w_c = $clog2(depth_p);
  localparam logic [ptr_w_c:0] full_c  = (ptr_w_c + 1)'(depth_p);

  key_event_t         mem_q [depth_p];
  logic [ptr_w_c-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_c-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_c:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               push, pop;

  always_comb begin
    pop        = valid_q && out_ready_i;
    in_ready_o = (count_q != full_c) || out_ready_i;
    push       = in_valid_i && in_ready_o;
    wr_ptr_d   = push ? wr_ptr_q + ptr_w_c'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ptr_w_c'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + (ptr_w_c + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ptr_w_c + 1)'(1);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Storage is not reset, so the head is masked until something is queued.
  assign out_valid_o = valid_q;
  assign out_data_o  = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/kpyd_scan_decoder.sv
// Keypad front end: timed active-low column scan, scan-level debounce and
// press/release event generation onto a valid/ready stream.
module kpyd_scan_decoder
  import kpyd_pkg::*;
#(
  parameter int scan_cycles_p    = 1200,
  parameter int debounce_scans_p = 4,
  parameter int fifo_depth_p     = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  kpyd_row_i,
  output logic [3:0]  kpyd_col_o,
  output logic        key_valid_o,
  input  logic        key_ready_i,
  output logic [3:0]  key_code_o,
  output logic        key_press_o,
  output logic [15:0] key_image_o
);

  localparam int dwell_w_c = $clog2(scan_cycles_p);
  localparam int match_w_c = (debounce_scans_p > 1) ? $clog2(debounce_scans_p) : 1;
  localparam logic [dwell_w_c-1:0] dwell_last_c = dwell_w_c'(scan_cycles_p - 1);
  localparam logic [match_w_c-1:0] match_top_c  = match_w_c'(debounce_scans_p - 1);

  logic [3:0]           col_q, col_d;
  logic [1:0]           col_idx_q, col_idx_d;
  logic [dwell_w_c-1:0] dwell_q, dwell_d;
  logic [15:0]          scan_q, scan_d;
  logic [15:0]          prev_q, prev_d;
  logic [match_w_c-1:0] match_q, match_d;
  logic                 accept_q, accept_d;
  logic [15:0]          stable_q, stable_d;
  logic [15:0]          commit_q, commit_d;

  logic        sample, scan_done;
  logic [15:0] diff;
  logic [3:0]  emit_idx;
  logic        emit_valid, emit_ready;
  key_event_t  emit_evt, out_evt;

  always_comb begin
    sample    = (dwell_q == dwell_last_c);
    scan_done = sample && (col_idx_q == 2'd3);
    dwell_d   = sample ? '0 : dwell_q + dwell_w_c'(1);
    col_d     = sample ? {col_q[2:0], col_q[3]} : col_q;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

    // Rows are only trusted at the end of the dwell, after the column has settled.
    scan_d = scan_q;
    if (sample) begin
      scan_d[{2'd0, col_idx_q}] = ~kpyd_row_i[0];
      scan_d[{2'd1, col_idx_q}] = ~kpyd_row_i[1];
      scan_d[{2'd2, col_idx_q}] = ~kpyd_row_i[2];
      scan_d[{2'd3, col_idx_q}] = ~kpyd_row_i[3];
    end

    prev_d   = prev_q;
    match_d  = match_q;
    accept_d = 1'b0;
    if (scan_done) begin
      prev_d = scan_d;
      if (scan_d != prev_q) begin
        match_d = '0;
      end else if (match_q != match_top_c) begin
        match_d = match_q + match_w_c'(1);
      end
      accept_d = (match_d == match_top_c);
    end

    stable_d = accept_q ? prev_q : stable_q;

    // Lowest differing position wins, so simultaneous changes drain in ascending order.
    diff     = stable_q ^ commit_q;
    emit_idx = '0;
    for (int i = num_keys_c - 1; i >= 0; i--) begin
      if (diff[4'(i)]) begin
        emit_idx = 4'(i);
      end
    end
    emit_valid     = |diff;
    emit_evt.code  = emit_idx;
    emit_evt.press = stable_q[emit_idx];

    commit_d = commit_q;
    if (emit_valid && emit_ready) begin
      commit_d[emit_idx] = stable_q[emit_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      col_q     <= col_reset_c;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      scan_q    <= '0;
      prev_q    <= '0;
      match_q   <= '0;
      accept_q  <= 1'b0;
      stable_q  <= '0;
      commit_q  <= '0;
    end else begin
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      scan_q    <= scan_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      accept_q  <= accept_d;
      stable_q  <= stable_d;
      commit_q  <= commit_d;
    end
  end

  kpyd_event_fifo #(
    .depth_p(fifo_depth_p)
  ) u_event_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .in_valid_i (emit_valid),
    .in_ready_o (emit_ready),
    .in_data_i  (emit_evt),
    .out_valid_o(key_valid_o),
    .out_ready_i(key_ready_i),
    .out_data_o (out_evt)
  );

  assign kpyd_col_o  = col_q;
  assign key_code_o  = out_evt.code;
  assign key_press_o = out_evt.press;
  assign key_image_o = commit_q;

endmodule

// File: tb/tb_kpyd_scan_decoder.sv
// Bench for kpyd_scan_decoder: a virtual keypad drives the rows from the held
// key set, and a scan-level reference model predicts the event stream.
module tb_kpyd_scan_decoder;

  localparam int SCAN = 4;
  localparam int DEB  = 2;
  localparam int SCAN_LEN = 4 * SCAN;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  kpyd_row;
  logic [3:0]  kpyd_col;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_press;
  logic [15:0] key_image;

  logic [15:0] keys;
  bit          rnd_ready;
  int          total = 0;
  int          bad   = 0;

  // Reference model state: recent full-scan images, committed key state, expected events.
  logic [15:0] hist_q[$];
  logic [15:0] m_commit;
  logic [4:0]  exp_q[$];
  logic [4:0]  got_q[$];

  kpyd_scan_decoder #(
    .scan_cycles_p   (SCAN),
    .debounce_scans_p(DEB),
    .fifo_depth_p    (4)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .kpyd_row_i (kpyd_row),
    .kpyd_col_o (kpyd_col),
    .key_valid_o(key_valid),
    .key_ready_i(key_ready),
    .key_code_o (key_code),
    .key_press_o(key_press),
    .key_image_o(key_image)
  );

  initial forever #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    kpyd_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!kpyd_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[r * 4 + c]) kpyd_row[r] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && key_valid && key_ready) got_q.push_back({key_code, key_press});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // An image is accepted once the last DEB full scans were all identical to it.
  function automatic void model_scan(input logic [15:0] img);
    bit same;
    hist_q.push_back(img);
    if (hist_q.size() > DEB) void'(hist_q.pop_front());
    if (hist_q.size() != DEB) return;
    same = 1'b1;
    foreach (hist_q[i]) if (hist_q[i] != img) same = 1'b0;
    if (!same) return;
    for (int i = 0; i < 16; i++) begin
      if (img[i] != m_commit[i]) begin
        exp_q.push_back({4'(i), img[i]});
        m_commit[i] = img[i];
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) key_ready = ($urandom_range(7) != 0);
  endtask

  task automatic scan(input logic [15:0] k);
    keys = k;
    repeat (SCAN_LEN) tick();
    model_scan(k);
  endtask

  // One scan, then cycle-exact checks of the burst of events its acceptance produces.
  task automatic scan_burst(input logic [15:0] k);
    int n0;
    int n;
    n0   = exp_q.size();
    keys = k;
    repeat (SCAN_LEN) tick();
    model_scan(k);
    n = exp_q.size() - n0;
    tick();
    check("lat_early_valid", key_valid, 0);
    for (int j = 0; j < n; j++) begin
      tick();
      check("burst_valid", key_valid, 1);
      check("burst_event", {key_code, key_press}, exp_q[n0 + j]);
    end
    repeat (SCAN_LEN - 1 - n) tick();
    model_scan(k);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_event"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [3:0]  exp_col;
    logic [15:0] cur;
    int          nscan;

    rnd_ready = 1'b0;
    keys      = '0;
    key_ready = 1'b1;
    reset_n   = 1'b0;
    m_commit  = '0;

    // Reset values and column rotation
    repeat (3) @(negedge clk);
    check("rst_col", kpyd_col, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_image", key_image, 0);
    check("rst_code", {key_code, key_press}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < SCAN_LEN; i++) begin
      if (i % SCAN == 0) begin
        exp_col = 4'hF ^ (4'h1 << (i / SCAN));
        check("col_rotate", kpyd_col, exp_col);
      end
      tick();
    end
    check("col_wrap", kpyd_col, 4'b1110);
    model_scan('0);

    // Single key at row 1 / column 2
    scan(16'h0040);
    scan_burst(16'h0040);
    check("single_image", key_image, 16'h0040);
    scan(16'h0000);
    scan_burst(16'h0000);
    check("single_release_image", key_image, 16'h0000);
    check_events("single");

    // A one-scan bounce must not produce events
    scan(16'h0001);
    check("bounce_image_a", key_image, 16'h0000);
    scan(16'h0000);
    scan(16'h0000);
    check("bounce_image_b", key_image, 16'h0000);
    check_events("bounce");

    // Several keys accepted together drain on consecutive cycles
    scan(16'h1208);
    scan_burst(16'h1208);
    check("multi_image", key_image, 16'h1208);
    scan(16'h0000);
    scan(16'h0000);
    scan(16'h0000);
    check("multi_release_image", key_image, 16'h0000);
    check_events("multi");

    // Backpressure: five events against a four-entry FIFO
    key_ready = 1'b0;
    scan(16'h0037);
    scan(16'h0037);
    scan(16'h0037);
    check("bp_valid", key_valid, 1);
    check("bp_head", {key_code, key_press}, {4'd0, 1'b1});
    check("bp_image_stall", key_image, 16'h0017);
    scan(16'h0037);
    check("bp_head_hold", {key_code, key_press}, {4'd0, 1'b1});
    check("bp_image_hold", key_image, 16'h0017);
    check("bp_none_taken", got_q.size(), 0);
    key_ready = 1'b1;
    scan(16'h0037);
    check("bp_image_done", key_image, 16'h0037);
    check_events("bp");
    scan(16'h0000);
    scan(16'h0000);
    scan(16'h0000);
    check_events("bp_release");

    // Reset with events pending discards them; held keys are re-reported
    key_ready = 1'b0;
    scan(16'h0300);
    scan(16'h0300);
    scan(16'h0300);
    check("mid_valid", key_valid, 1);
    check("mid_none_taken", got_q.size(), 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_image", key_image, 0);
    check("mid_rst_col", kpyd_col, 4'b1110);
    @(negedge clk);
    reset_n = 1'b1;
    key_ready = 1'b1;
    exp_q.delete();
    got_q.delete();
    hist_q.delete();
    m_commit = '0;
    scan(16'h0300);
    scan_burst(16'h0300);
    check("regen_image", key_image, 16'h0300);
    check_events("regen");

    // Random single-key toggles with random hold lengths and random consumer stalls
    cur = 16'h0300;
    rnd_ready = 1'b1;
    for (int it = 0; it < 14; it++) begin
      cur   = cur ^ (16'h0001 << $urandom_range(15));
      nscan = $urandom_range(3, 1);
      repeat (nscan) scan(cur);
    end
    rnd_ready = 1'b0;
    key_ready = 1'b1;
    scan(cur);
    scan(cur);
    scan(cur);
    check("rnd_image", key_image, m_commit);
    check_events("rnd");
    scan(16'h0000);
    scan(16'h0000);
    scan(16'h0000);
    check("final_image", key_image, 16'h0000);
    check_events("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kpyd_scan_decoder.md
Name: kpyd_scan_decoder

Overview:
Sequential keypad front end that replaces the free-running column shifter and the combinational key-to-segment path. It drives the 4x4 keypad columns with a timed active-low scan and assembles a 16-bit key image from the row inputs. It debounces the image and decodes it into discrete press/release events. Events go out on a valid/ready stream consumed by the display/LED logic in top.

Parameters:
scan_cycles_p, 1200, clock cycles each column is held low (100 us at 12 MHz); legal range >= 2
debounce_scans_p, 4, consecutive identical full scans required before an image is accepted; legal range >= 1
fifo_depth_p, 4, event FIFO entries; power of two, >= 2

Ports:
clk_i  input  1  system clock
reset_n_i  input  1  synchronous reset, active low
kpyd_row_i  input  4  keypad rows, active low, already two-flop synchronized by caller
kpyd_col_o  output  4  keypad column drive, active low, exactly one bit low at all times
key_valid_o  output  1  event available
key_ready_i  input  1  consumer accepts event when valid & ready on a rising edge
key_code_o  output  4  key position index = row*4 + col
key_press_o  output  1  1 = press, 0 = release
key_image_o  output  16  current committed (debounced) key state, bit i = key i held

Behaviour:
- Reset (reset_n_i low at a clock edge):
  - kpyd_col_o = 4'b1110 (column 0 active).
  - Dwell counter = 0; scan image = 0; debounce count = 0; committed state = 0.
  - FIFO empty, so key_valid_o = 0; key_code_o = 0; key_press_o = 0; key_image_o = 0.
  - Reset mid-scan or mid-handshake discards all pending events.
- Column scan:
  - Column c is held low for scan_cycles_p cycles, then rotates c -> c+1 mod 4.
  - Pattern order: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Row sampling:
  - Rows are sampled only on the last dwell cycle of each column, which gives settling time.
  - Bit row*4+c of the scan image = ~kpyd_row_i[row].
  - A full scan completes on the column-3 sample cycle.
- Debounce, on each scan completion:
  - If image == previous image, increment the match count, saturating at debounce_scans_p-1; otherwise clear it to 0.
  - The image is accepted when the count reaches debounce_scans_p-1, i.e. identical for debounce_scans_p consecutive scans.
  - An accepted image is copied to the stable register on the next cycle.
  - debounce_scans_p = 1 accepts every scan.
- Event emitter:
  - Each cycle, if stable != committed and the FIFO is not full, take the lowest differing index i.
  - Enqueue {i, stable[i]} and flip committed[i] in the same cycle.
  - At most one event per cycle; multiple changes drain in ascending index order.
  - While the FIFO is full, the emitter stalls. No event is ever dropped or duplicated, and scanning continues.
  - A key that is pressed and released before acceptance produces no events.
  - If stable changes while a difference is still draining, the emitter compares against the new stable value. Net state is preserved and pairs are never unbalanced.
- Latency: with an empty FIFO, key_valid_o rises exactly 2 cycles after the accepting column-3 sample cycle.
- Output handshake:
  - key_code_o and key_press_o are held stable while key_valid_o = 1 and key_ready_i = 0.
  - Simultaneous enqueue and dequeue on a full FIFO is legal and keeps the count unchanged.
  - key_valid_o is registered and never depends combinationally on key_ready_i.
- key_image_o = committed register, so it reflects only events already enqueued.

Decomposition:
- kpyd_pkg:
  - key_event_t packed struct {logic [3:0] code; logic press;}
  - localparam col_reset_c = 4'b1110
  - localparam num_keys_c = 16
  - 16-entry key legend table (position index -> hex digit) for downstream display
- Sub-module kpyd_event_fifo:
  - Synchronous FIFO of key_event_t, parameterized depth, valid/ready on both sides, active-low synchronous reset.
- Scan, debounce and emitter logic live in kpyd_scan_decoder.

Test Plan:
(bench: scan_cycles_p=4, debounce_scans_p=2, fifo_depth_p=4; full scan = 16 cycles)
1. Reset sequence: hold reset_n_i=0 for 3 cycles, rows=1111 -> kpyd_col_o=1110, valid=0, image=0. After release, col changes every 4 cycles 1110,1101,1011,0111,1110.
2. Single key press: drive row1 low only while col=1011, held across 3 scans, key_ready_i=1 -> one event code=6, press=1, valid 2 cycles after the second scan's column-3 sample; key_image_o=16'h0040. Release -> one event code=6, press=0; image=0.
3. Bounce rejection: press row0/col0 for exactly 1 scan then release -> no events, image stays 0.
4. Multiple keys: keys 3, 9, 12 become held together -> three press events in order 3, 9, 12 on consecutive cycles; image=16'h1208.
5. Backpressure: key_ready_i=0, 5 keys (0,1,2,4,5) accepted -> FIFO holds 0,1,2,4 with code stable and valid=1. After ready=1, events 0,1,2,4,5 are delivered in order with none lost; image reaches 16'h0037 only after 5 is enqueued.
6. Reset mid-operation: reset_n_i low while 2 events are queued -> valid=0 next cycle, image=0. After release with keys still held, press events are regenerated after debounce.
